// File: rtl/adc_capture_trigger.sv
// Pre/post-trigger capture of decimated ADC samples into a circular sample RAM.
// Freezes after the post-trigger window; re-arms on a rising edge of VGA_WRITE_DONE.
//
// state     | meaning
// ARM       | filling the pre-trigger window, trigger ignored
// WAIT_TRIG | writing continuously, watching for a level crossing or timeout
// POST      | writing the post-trigger window
// HOLD      | capture frozen until the display stage releases it
module adc_capture_trigger #(
    parameter int RAM_AW       = 11,
    parameter int PRE_SAMPLES  = 320,
    parameter int POST_SAMPLES = 320,
    parameter int AUTO_TIMEOUT = 2048
) (
    input  logic              CLK_50MHZ,
    input  logic              MASTER_RST,
    input  logic [7:0]        ADC_DATA,
    input  logic [5:0]        TIME_BASE,
    input  logic [7:0]        TRIG_LEVEL,
    input  logic              TRIG_SLOPE,
    input  logic              VGA_WRITE_DONE,
    output logic [7:0]        ADC_RAM_WR_DATA,
    output logic [RAM_AW-1:0] ADC_RAM_WR_ADDR,
    output logic              ADC_RAM_WE,
    output logic [RAM_AW-1:0] TRIG_ADDR,
    output logic              CAPTURE_DONE,
    output logic              TRIG_AUTO
);

    localparam int SMP_MAX = (PRE_SAMPLES > POST_SAMPLES) ? PRE_SAMPLES : POST_SAMPLES;
    localparam int SCW     = $clog2(SMP_MAX + 1);
    localparam int TCW     = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [SCW-1:0] PRE_LAST  = SCW'(PRE_SAMPLES - 1);
    localparam logic [SCW-1:0] POST_LAST = SCW'(POST_SAMPLES - 1);
    localparam logic [TCW-1:0] TMO_MAX   = TCW'(AUTO_TIMEOUT);

    typedef enum logic [1:0] {ARM, WAIT_TRIG, POST, HOLD} state_t;

    state_t            state;
    logic [5:0]        presc;
    logic [RAM_AW-1:0] waddr;
    logic [SCW-1:0]    smp_cnt;
    logic [TCW-1:0]    tmo_cnt;
    logic [7:0]        prev;
    logic              vga_q;
    logic              strobe;
    logic              level_hit;
    logic              vga_rise;

    // >= rather than == so a TIME_BASE lowered mid-count still strobes promptly
    assign strobe   = (presc >= TIME_BASE);
    assign vga_rise = VGA_WRITE_DONE & ~vga_q;

    always_comb begin
        level_hit = 1'b0;
        if (TRIG_SLOPE)
            level_hit = (prev > TRIG_LEVEL) && (ADC_DATA <= TRIG_LEVEL);
        else
            level_hit = (prev < TRIG_LEVEL) && (ADC_DATA >= TRIG_LEVEL);
    end

    always_ff @(posedge CLK_50MHZ or posedge MASTER_RST) begin
        if (MASTER_RST)
            presc <= '0;
        else if (strobe)
            presc <= '0;
        else
            presc <= presc + 6'd1;
    end

    always_ff @(posedge CLK_50MHZ or posedge MASTER_RST) begin
        if (MASTER_RST) begin
            state           <= ARM;
            waddr           <= '0;
            smp_cnt         <= '0;
            tmo_cnt         <= '0;
            prev            <= '0;
            vga_q           <= 1'b0;
            ADC_RAM_WE      <= 1'b0;
            ADC_RAM_WR_DATA <= '0;
            ADC_RAM_WR_ADDR <= '0;
            TRIG_ADDR       <= '0;
            CAPTURE_DONE    <= 1'b0;
            TRIG_AUTO       <= 1'b0;
        end else begin
            vga_q      <= VGA_WRITE_DONE;
            ADC_RAM_WE <= 1'b0;
            if (strobe)
                prev <= ADC_DATA;

            if (state != HOLD && strobe) begin
                ADC_RAM_WR_DATA <= ADC_DATA;
                ADC_RAM_WR_ADDR <= waddr;
                ADC_RAM_WE      <= 1'b1;
                waddr           <= waddr + 1'b1;
            end

            case (state)
                ARM: begin
                    if (strobe) begin
                        if (smp_cnt == PRE_LAST) begin
                            smp_cnt <= '0;
                            tmo_cnt <= '0;
                            state   <= WAIT_TRIG;
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                WAIT_TRIG: begin
                    // a genuine crossing takes priority over the timeout
                    if (strobe) begin
                        if (level_hit) begin
                            TRIG_ADDR <= waddr;
                            TRIG_AUTO <= 1'b0;
                            smp_cnt   <= '0;
                            state     <= POST;
                        end else if (tmo_cnt == TMO_MAX) begin
                            TRIG_ADDR <= waddr;
                            TRIG_AUTO <= 1'b1;
                            smp_cnt   <= '0;
                            state     <= POST;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                end
                POST: begin
                    if (strobe) begin
                        if (smp_cnt == POST_LAST) begin
                            smp_cnt <= '0;
                            state   <= HOLD;
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // done flag waits one cycle so the final RAM write has landed
                    CAPTURE_DONE <= 1'b1;
                    if (vga_rise) begin
                        CAPTURE_DONE <= 1'b0;
                        state        <= ARM;
                    end
                end
                default: state <= ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_trigger.sv
// Directed bench for adc_capture_trigger: ramp, auto, falling-slope and reset-abort captures.
module tb_adc_capture_trigger;

    logic        CLK_50MHZ = 1'b0;
    logic        MASTER_RST = 1'b1;
    logic [7:0]  ADC_DATA;
    logic [5:0]  TIME_BASE;
    logic [7:0]  TRIG_LEVEL;
    logic        TRIG_SLOPE;
    logic        VGA_WRITE_DONE;
    logic [7:0]  ADC_RAM_WR_DATA;
    logic [10:0] ADC_RAM_WR_ADDR;
    logic        ADC_RAM_WE;
    logic [10:0] TRIG_ADDR;
    logic        CAPTURE_DONE;
    logic        TRIG_AUTO;

    int errs   = 0;
    int checks = 0;
    int exp_addr;
    int n_w;
    int mode;

    adc_capture_trigger dut (
        .CLK_50MHZ      (CLK_50MHZ),
        .MASTER_RST     (MASTER_RST),
        .ADC_DATA       (ADC_DATA),
        .TIME_BASE      (TIME_BASE),
        .TRIG_LEVEL     (TRIG_LEVEL),
        .TRIG_SLOPE     (TRIG_SLOPE),
        .VGA_WRITE_DONE (VGA_WRITE_DONE),
        .ADC_RAM_WR_DATA(ADC_RAM_WR_DATA),
        .ADC_RAM_WR_ADDR(ADC_RAM_WR_ADDR),
        .ADC_RAM_WE     (ADC_RAM_WE),
        .TRIG_ADDR      (TRIG_ADDR),
        .CAPTURE_DONE   (CAPTURE_DONE),
        .TRIG_AUTO      (TRIG_AUTO)
    );

    always #10 CLK_50MHZ = ~CLK_50MHZ;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // sample value presented for the n-th write since (re)arm
    function automatic logic [7:0] data_for(input int n);
        case (mode)
            0:       return 8'(n + 192);
            1:       return 8'd50;
            default: begin
                if (n < 320)            return 8'd200;
                else if (n - 320 > 200) return 8'd0;
                else                    return 8'(200 - (n - 320));
            end
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"},    ADC_RAM_WE, 0);
        chk({tag, "_wdata"}, ADC_RAM_WR_DATA, 0);
        chk({tag, "_waddr"}, ADC_RAM_WR_ADDR, 0);
        chk({tag, "_taddr"}, TRIG_ADDR, 0);
        chk({tag, "_done"},  CAPTURE_DONE, 0);
        chk({tag, "_auto"},  TRIG_AUTO, 0);
    endtask

    task automatic run(input int exp_writes, input bit stop_early, input int budget, input int gap);
        int cyc  = 0;
        int last = -1;
        bit fin  = 0;
        n_w = 0;
        while (!fin) begin
            @(posedge CLK_50MHZ); #1;
            cyc++;
            if (ADC_RAM_WE) begin
                chk("wr_addr", ADC_RAM_WR_ADDR, exp_addr);
                chk("wr_data", ADC_RAM_WR_DATA, data_for(n_w));
                chk("done_while_writing", CAPTURE_DONE, 0);
                if (gap > 0 && last >= 0) chk("we_gap", cyc - last, gap);
                last     = cyc;
                exp_addr = (exp_addr + 1) % 2048;
                n_w++;
                ADC_DATA = data_for(n_w);
                if (stop_early && n_w == exp_writes) fin = 1;
            end
            if (CAPTURE_DONE) fin = 1;
            if (cyc >= budget) fin = 1;
        end
        chk("n_writes", n_w, exp_writes);
        if (!stop_early) begin
            chk("capture_done", CAPTURE_DONE, 1);
            chk("we_in_hold", ADC_RAM_WE, 0);
        end
    endtask

    task automatic rearm(input int kept_trig_addr);
        VGA_WRITE_DONE = 1'b0;
        repeat (3) @(posedge CLK_50MHZ);
        #1;
        chk("hold_before_rise", CAPTURE_DONE, 1);
        VGA_WRITE_DONE = 1'b1;
        @(posedge CLK_50MHZ); #1;
        chk("arm_done_low", CAPTURE_DONE, 0);
        chk("arm_no_write", ADC_RAM_WE, 0);
        chk("arm_trig_kept", TRIG_ADDR, kept_trig_addr);
    endtask

    initial begin
        TIME_BASE      = 6'd0;
        TRIG_LEVEL     = 8'd100;
        TRIG_SLOPE     = 1'b0;
        VGA_WRITE_DONE = 1'b1;
        mode           = 0;
        ADC_DATA       = data_for(0);

        repeat (3) @(posedge CLK_50MHZ);
        #1;
        check_reset_outputs("rst");
        MASTER_RST = 1'b0;
        exp_addr   = 0;

        // rising ramp, one sample per clock
        run(741, 1'b0, 3000, 1);
        chk("ramp_trig_addr", TRIG_ADDR, 420);
        chk("ramp_trig_auto", TRIG_AUTO, 0);
        chk("ramp_last_addr", ADC_RAM_WR_ADDR, 740);

        // done level already high on HOLD entry must not re-arm
        repeat (10) @(posedge CLK_50MHZ);
        #1;
        chk("hold_level_high", CAPTURE_DONE, 1);
        chk("hold_we", ADC_RAM_WE, 0);

        // constant input: forced trigger, address wraps through 2047 -> 0
        mode     = 1;
        ADC_DATA = data_for(0);
        rearm(420);
        run(2689, 1'b0, 6000, 1);
        chk("auto_trig_addr", TRIG_ADDR, 1061);
        chk("auto_trig_auto", TRIG_AUTO, 1);
        chk("auto_last_addr", ADC_RAM_WR_ADDR, 1381);
        repeat (5) @(posedge CLK_50MHZ);
        #1;
        chk("auto_hold", CAPTURE_DONE, 1);

        // decimated falling ramp
        TIME_BASE  = 6'd3;
        TRIG_SLOPE = 1'b1;
        TRIG_LEVEL = 8'd80;
        mode       = 2;
        ADC_DATA   = data_for(0);
        rearm(1061);
        run(761, 1'b0, 4000, 4);
        chk("fall_trig_addr", TRIG_ADDR, 1822);
        chk("fall_trig_auto", TRIG_AUTO, 0);
        chk("fall_last_addr", ADC_RAM_WR_ADDR, 94);

        // reset in the middle of the post-trigger window
        TIME_BASE  = 6'd0;
        TRIG_SLOPE = 1'b0;
        TRIG_LEVEL = 8'd100;
        mode       = 0;
        ADC_DATA   = data_for(0);
        rearm(1822);
        run(500, 1'b1, 1000, 1);
        chk("post_trig_addr", TRIG_ADDR, 515);
        chk("post_done", CAPTURE_DONE, 0);
        MASTER_RST = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(posedge CLK_50MHZ); #1;
        chk("abort_we_held", ADC_RAM_WE, 0);
        ADC_DATA   = data_for(0);
        MASTER_RST = 1'b0;
        exp_addr   = 0;
        run(5, 1'b1, 100, 1);
        chk("restart_addr", ADC_RAM_WR_ADDR, 4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
